// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// address width and default boot/HALT constants.
package fetch_pkg;

   localparam int ADDR_W = 8;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT    = 8'h00;
   localparam logic [ADDR_W-1:0] HALT_OPCODE_DEFAULT = 8'hFF;

   typedef enum logic [2:0] {
      ST_BOOT     = 3'd0,
      ST_RUN      = 3'd1,
      ST_REDIRECT = 3'd2,
      ST_HALT     = 3'd3,
      ST_RESUME   = 3'd4
   } state_t;

endpackage

// File: rtl/fetch_if.sv
// Control bundle between the fetch controller (master) and the fetch
// datapath / pipeline neighbours (slave).
interface fetch_if;
   import fetch_pkg::*;

   logic              stall_req;
   logic              jump_req;
   logic [ADDR_W-1:0] jump_addr;
   logic [ADDR_W-1:0] inst;
   logic              resume;
   logic              pc_en;
   logic              choice_mux;
   logic [ADDR_W-1:0] pcj_mux;
   logic              ifid_write;
   logic              ifid_flush;
   state_t            state;
   logic [15:0]       fetch_count;

   modport master (
      input  stall_req, jump_req, jump_addr, inst, resume,
      output pc_en, choice_mux, pcj_mux, ifid_write, ifid_flush, state, fetch_count
   );

   modport slave (
      output stall_req, jump_req, jump_addr, inst, resume,
      input  pc_en, choice_mux, pcj_mux, ifid_write, ifid_flush, state, fetch_count
   );

endinterface

// File: rtl/fetch_sat_counter16.sv
// 16-bit up counter with increment enable that sticks at all-ones instead of
// wrapping; cleared asynchronously by reset.
module sat_counter16 (
   input  logic        clock,
   input  logic        reset,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg <= 16'h0000;
      end else if (inc && (count_reg != 16'hFFFF)) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns PC enable, PC mux select/target and IF/ID
// load/flush, handling boot, jump redirects, stalls and HALT/resume.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int unsigned       BUBBLES     = 1,
   parameter logic [ADDR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
   input  logic    clock,
   input  logic    reset,
   fetch_if.master bus
);

   localparam logic [1:0] BUBBLES_INIT = 2'(BUBBLES);

   state_t            state_reg, state_next;
   logic              choice_mux_reg, choice_mux_next;
   logic [ADDR_W-1:0] pcj_mux_reg, pcj_mux_next;
   logic              ifid_flush_reg, ifid_flush_next;
   logic [1:0]        flush_cnt_reg, flush_cnt_next;
   logic              pc_en;
   logic              ifid_write;
   logic              jump_taken;
   logic [15:0]       fetch_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_BOOT;
         choice_mux_reg <= 1'b1;
         pcj_mux_reg    <= RESET_PC;
         ifid_flush_reg <= 1'b1;
         flush_cnt_reg  <= 2'd0;
      end else begin
         state_reg      <= state_next;
         choice_mux_reg <= choice_mux_next;
         pcj_mux_reg    <= pcj_mux_next;
         ifid_flush_reg <= ifid_flush_next;
         flush_cnt_reg  <= flush_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      choice_mux_next = choice_mux_reg;
      pcj_mux_next    = pcj_mux_reg;
      ifid_flush_next = ifid_flush_reg;
      flush_cnt_next  = flush_cnt_reg;
      pc_en           = 1'b0;
      ifid_write      = 1'b0;
      jump_taken      = 1'b0;

      case (state_reg)
         ST_BOOT: begin
            pc_en           = 1'b1;
            choice_mux_next = 1'b0;
            ifid_flush_next = 1'b0;
            state_next      = ST_RUN;
         end
         ST_RUN: begin
            if (bus.jump_req) begin
               jump_taken = 1'b1;
            end else if ((bus.inst == HALT_OPCODE) && !bus.stall_req) begin
               // The HALT word itself is issued once, then fetch freezes.
               ifid_write      = 1'b1;
               ifid_flush_next = 1'b1;
               state_next      = ST_HALT;
            end else if (!bus.stall_req) begin
               pc_en      = 1'b1;
               ifid_write = 1'b1;
            end
         end
         ST_REDIRECT: begin
            pc_en           = 1'b1;
            choice_mux_next = 1'b0;
            if (bus.jump_req) begin
               jump_taken = 1'b1;
            end else begin
               flush_cnt_next = flush_cnt_reg - 2'd1;
               if (flush_cnt_reg == 2'd1) begin
                  ifid_flush_next = 1'b0;
                  state_next      = ST_RUN;
               end
            end
         end
         ST_HALT: begin
            if (bus.jump_req) begin
               jump_taken = 1'b1;
            end else if (bus.resume) begin
               state_next = ST_RESUME;
            end
         end
         ST_RESUME: begin
            pc_en           = 1'b1;
            ifid_flush_next = 1'b0;
            state_next      = ST_RUN;
         end
         default: begin
            state_next      = ST_BOOT;
            choice_mux_next = 1'b1;
            pcj_mux_next    = RESET_PC;
            ifid_flush_next = 1'b1;
            flush_cnt_next  = 2'd0;
         end
      endcase

      // A taken jump always wins over stall, HALT and resume in the same cycle.
      if (jump_taken) begin
         pc_en           = 1'b1;
         ifid_write      = 1'b0;
         pcj_mux_next    = bus.jump_addr;
         choice_mux_next = 1'b1;
         ifid_flush_next = 1'b1;
         flush_cnt_next  = BUBBLES_INIT;
         state_next      = ST_REDIRECT;
      end
   end

   sat_counter16 u_count (
      .clock (clock),
      .reset (reset),
      .inc   (ifid_write),
      .count (fetch_count)
   );

   assign bus.pc_en       = pc_en;
   assign bus.ifid_write  = ifid_write;
   assign bus.choice_mux  = choice_mux_reg;
   assign bus.pcj_mux     = pcj_mux_reg;
   assign bus.ifid_flush  = ifid_flush_reg;
   assign bus.state       = state_reg;
   assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a behavioural model predicts every
// cycle's outputs into a queue, a monitor pops and compares them.
module tb_fetch_controller;
   import fetch_pkg::*;

   localparam int         BUB      = 2;
   localparam logic [7:0] BOOT_PC  = 8'h00;
   localparam logic [7:0] HALT_OP  = 8'hFF;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fetch_if bus ();

   fetch_controller #(
      .RESET_PC    (BOOT_PC),
      .BUBBLES     (BUB),
      .HALT_OPCODE (HALT_OP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       pc_en;
      logic       ifid_write;
      logic       choice_mux;
      logic [7:0] pcj_mux;
      logic       ifid_flush;
      int         st;
      int         cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   txn   = 0;

   // Model: what the fetch stage is doing, not how the RTL encodes it.
   bit         m_booting;
   bit         m_halted;
   bit         m_resuming;
   bit         m_target_cycle;
   int         m_bubbles_left;
   logic [7:0] m_target;
   int         m_count;

   function automatic void model_reset();
      m_booting      = 1'b1;
      m_halted       = 1'b0;
      m_resuming     = 1'b0;
      m_target_cycle = 1'b0;
      m_bubbles_left = 0;
      m_target       = BOOT_PC;
      m_count        = 0;
   endfunction

   function automatic exp_t model_expect(logic stall, logic jump, logic [7:0] inst);
      exp_t e;
      e.pcj_mux    = m_target;
      e.cnt        = m_count;
      e.choice_mux = m_booting || m_target_cycle;
      e.ifid_flush = m_booting || (m_bubbles_left > 0) || m_halted || m_resuming;
      if (m_booting) begin
         e.st = 0; e.pc_en = 1'b1; e.ifid_write = 1'b0;
      end else if (m_bubbles_left > 0) begin
         e.st = 2; e.pc_en = 1'b1; e.ifid_write = 1'b0;
      end else if (m_halted) begin
         e.st = 3; e.pc_en = jump; e.ifid_write = 1'b0;
      end else if (m_resuming) begin
         e.st = 4; e.pc_en = 1'b1; e.ifid_write = 1'b0;
      end else begin
         e.st = 1;
         if (jump) begin
            e.pc_en = 1'b1; e.ifid_write = 1'b0;
         end else if (inst == HALT_OP && !stall) begin
            e.pc_en = 1'b0; e.ifid_write = 1'b1;
         end else begin
            e.pc_en = !stall; e.ifid_write = !stall;
         end
      end
      return e;
   endfunction

   function automatic void start_jump(logic [7:0] addr);
      m_target       = addr;
      m_bubbles_left = BUB;
      m_target_cycle = 1'b1;
      m_halted       = 1'b0;
   endfunction

   function automatic void issue();
      if (m_count < 65535) m_count = m_count + 1;
   endfunction

   function automatic void model_step(logic stall, logic jump, logic [7:0] addr,
                                      logic [7:0] inst, logic res);
      if (m_booting) begin
         m_booting = 1'b0;
      end else if (m_bubbles_left > 0) begin
         if (jump) start_jump(addr);
         else begin
            m_bubbles_left = m_bubbles_left - 1;
            m_target_cycle = 1'b0;
         end
      end else if (m_halted) begin
         if (jump) start_jump(addr);
         else if (res) begin
            m_halted   = 1'b0;
            m_resuming = 1'b1;
         end
      end else if (m_resuming) begin
         m_resuming = 1'b0;
      end else if (jump) begin
         start_jump(addr);
      end else if (inst == HALT_OP && !stall) begin
         issue();
         m_halted = 1'b1;
      end else if (!stall) begin
         issue();
      end
   endfunction

   task automatic drive_cycle(input logic rst, input logic stall, input logic jump,
                              input logic [7:0] addr, input logic [7:0] inst,
                              input logic res);
      @(negedge clock);
      reset         = rst;
      bus.stall_req = stall;
      bus.jump_req  = jump;
      bus.jump_addr = addr;
      bus.inst      = inst;
      bus.resume    = res;
      if (rst) model_reset();
      exp_q.push_back(model_expect(stall, jump, inst));
      if (!rst) model_step(stall, jump, addr, inst, res);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
   endtask

   task automatic cmp(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL txn %0d %s: got %0h want %0h", txn, name, act, req);
      end
   endtask

   // Monitor: compares once per cycle, mid-cycle after inputs have settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("state",       int'(bus.state),       e.st);
            cmp("pc_en",       int'(bus.pc_en),       int'(e.pc_en));
            cmp("ifid_write",  int'(bus.ifid_write),  int'(e.ifid_write));
            cmp("choice_mux",  int'(bus.choice_mux),  int'(e.choice_mux));
            cmp("pcj_mux",     int'(bus.pcj_mux),     int'(e.pcj_mux));
            cmp("ifid_flush",  int'(bus.ifid_flush),  int'(e.ifid_flush));
            cmp("fetch_count", int'(bus.fetch_count), e.cnt);
            $display("txn %0d rst=%0b st=%0d pc_en=%0b iw=%0b cm=%0b pcj=%02h fl=%0b cnt=%0h",
                     txn, reset, bus.state, bus.pc_en, bus.ifid_write, bus.choice_mux,
                     bus.pcj_mux, bus.ifid_flush, bus.fetch_count);
            txn++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.stall_req = 1'b0;
      bus.jump_req  = 1'b0;
      bus.jump_addr = 8'h00;
      bus.inst      = 8'h01;
      bus.resume    = 1'b0;
      model_reset();

      // Reset then free run
      drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
      idle(7);

      // Jump to 0x40
      drive_cycle(1'b0, 1'b0, 1'b1, 8'h40, 8'h01, 1'b0);
      idle(4);

      // Stall for three cycles with a jump in the second
      drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b1, 8'h77, 8'h01, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
      idle(3);

      // Halt, linger, resume
      drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, HALT_OP, 1'b0);
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, HALT_OP, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, HALT_OP, 1'b1);
      idle(3);

      // Back-to-back jumps, then reset in the middle of the redirect
      drive_cycle(1'b0, 1'b0, 1'b1, 8'h10, 8'h01, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b1, 8'h20, 8'h01, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
      idle(4);

      // Saturation: preload the counter while stalled, then keep issuing
      drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
      #3;
      force dut.u_count.count_reg = 16'hFFFC;
      #1;
      release dut.u_count.count_reg;
      m_count = 65532;
      idle(6);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         drive_cycle(($urandom_range(0, 149) == 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 9) == 0),
                     8'($urandom),
                     ($urandom_range(0, 11) == 0) ? HALT_OP : 8'($urandom),
                     ($urandom_range(0, 3) == 0));
      end

      @(negedge clock);
      #4;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
